// File: rtl/fcvt_pkg.sv
// Shared definitions for the float-to-int arbiter: output register states,
// saturation exponent and requester-ID width.
package fcvt_pkg;

   localparam int FCVT_ID_W = 1;

   // Biased exponent of 2^31; anything at or above it no longer fits int32.
   localparam logic [7:0] FCVT_EXP_OVF = 8'h9E;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } fcvt_state_e;

endpackage

// File: rtl/fcvt_f2i.sv
// Combinational IEEE-754 single to signed int32 conversion, truncating toward
// zero and saturating to 0x80000000 for out-of-range, Inf and NaN operands.
module fcvt_f2i
   import fcvt_pkg::*;
(
   input  logic [31:0] i_f,
   output logic [31:0] o_int,
   output logic        o_ovf
);

   logic        w_sign;
   logic [7:0]  w_exp;
   logic [22:0] w_man;
   logic [7:0]  w_sh;
   logic [31:0] w_mant;
   logic [31:0] w_mag;

   assign w_sign = i_f[31];
   assign w_exp  = i_f[30:23];
   assign w_man  = i_f[22:0];
   assign w_sh   = w_exp - 8'd127;
   assign w_mant = {8'd0, 1'b1, w_man};

   always_comb begin
      w_mag = '0;
      o_int = '0;
      o_ovf = 1'b0;
      if ((w_exp > FCVT_EXP_OVF) ||
          ((w_exp == FCVT_EXP_OVF) && !(w_sign && (w_man == 23'd0)))) begin
         o_ovf = 1'b1;
         o_int = 32'h8000_0000;
      end else if (w_exp == FCVT_EXP_OVF) begin
         // exactly -2^31 is representable
         o_int = 32'h8000_0000;
      end else if (w_exp >= 8'd127) begin
         if (w_sh >= 8'd23) w_mag = w_mant << (w_sh - 8'd23);
         else               w_mag = w_mant >> (8'd23 - w_sh);
         o_int = w_sign ? -w_mag : w_mag;
      end
   end

endmodule

// File: rtl/fcvt_arb.sv
// Two-requester arbiter in front of a shared float-to-int converter, with a
// single output register that can drain and reload in the same cycle.
//
// state | meaning
// EMPTY | output register holds nothing, rsp_valid=0
// FULL  | output register holds a result, rsp_valid=1
module fcvt_arb
   import fcvt_pkg::*;
#(
   parameter int FAIR = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req0_valid,
   input  logic [31:0]          req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [31:0]          req1_data,
   output logic                 req1_ready,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_data,
   output logic [FCVT_ID_W-1:0] rsp_id,
   output logic                 rsp_ovf,
   input  logic                 rsp_ready
);

   fcvt_state_e          r_state, w_state_nxt;
   logic [31:0]          r_data;
   logic [FCVT_ID_W-1:0] r_id;
   logic                 r_ovf;
   logic [FCVT_ID_W-1:0] r_last;

   logic [FCVT_ID_W-1:0] w_grant;
   logic                 w_accept_ok;
   logic                 w_accept;
   logic [31:0]          w_sel_data;
   logic [31:0]          w_cvt_int;
   logic                 w_cvt_ovf;

   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) w_grant = (FAIR != 0) ? ~r_last : 1'b0;
      else if (req1_valid)          w_grant = 1'b1;
   end

   assign w_accept_ok = (r_state == EMPTY) || rsp_ready;
   // rstn gates the readys so nothing is offered while the block is in reset
   assign req0_ready  = rstn && w_accept_ok && req0_valid && (w_grant == 1'b0);
   assign req1_ready  = rstn && w_accept_ok && req1_valid && (w_grant == 1'b1);
   assign w_accept    = req0_ready || req1_ready;
   assign w_sel_data  = (w_grant == 1'b1) ? req1_data : req0_data;

   fcvt_f2i u_f2i (
      .i_f   (w_sel_data),
      .o_int (w_cvt_int),
      .o_ovf (w_cvt_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY:   if (w_accept) w_state_nxt = FULL;
         FULL:    if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= EMPTY;
         r_data  <= '0;
         r_id    <= '0;
         r_ovf   <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_data <= w_cvt_int;
            r_id   <= w_grant;
            r_ovf  <= w_cvt_ovf;
            r_last <= w_grant;
         end
      end
   end

   assign rsp_valid = (r_state == FULL);
   assign rsp_data  = r_data;
   assign rsp_id    = r_id;
   assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_fcvt_arb.sv
// Scoreboard bench for fcvt_arb: directed operands push expected results, a
// monitor pops and compares each result the consumer takes.
module tb_fcvt_arb;

   logic        clk = 1'b0;
   logic        rstn;
   logic        v0, v1, rr;
   logic [31:0] d0, d1;

   logic        r0, r1, rv, rid, rovf;
   logic [31:0] rdat;
   logic        f_r0, f_r1, f_rv, f_rid, f_rovf;
   logic [31:0] f_rdat;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] d;
      logic        id;
      logic        ovf;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   fcvt_arb #(.FAIR(1)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
      .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
      .rsp_valid(rv), .rsp_data(rdat), .rsp_id(rid), .rsp_ovf(rovf),
      .rsp_ready(rr)
   );

   fcvt_arb #(.FAIR(0)) dut_fix (
      .clk(clk), .rstn(rstn),
      .req0_valid(v0), .req0_data(d0), .req0_ready(f_r0),
      .req1_valid(v1), .req1_data(d1), .req1_ready(f_r1),
      .rsp_valid(f_rv), .rsp_data(f_rdat), .rsp_id(f_rid), .rsp_ovf(f_rovf),
      .rsp_ready(rr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic id, input logic [31:0] data,
                       input logic [31:0] exp_d, input logic exp_ovf);
      bit got;
      tick();
      q.push_back('{d: exp_d, id: id, ovf: exp_ovf});
      if (id == 1'b0) begin v0 = 1'b1; d0 = data; end
      else            begin v1 = 1'b1; d1 = data; end
      got = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if ((id == 1'b0) ? r0 : r1) begin got = 1; break; end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: operand %h never accepted", data);
      end
      tick();
      v0 = 1'b0;
      v1 = 1'b0;
      @(negedge clk);
      chk("latency_valid", {31'd0, rv}, 32'd1);
   endtask

   // Monitor: every cycle the consumer takes a result, compare against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && rv === 1'b1 && rr === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got data %h id %0d, expected nothing", rdat, rid);
            end else begin
               e = q.pop_front();
               chk("rsp_data", rdat, e.d);
               chk("rsp_id", {31'd0, rid}, {31'd0, e.id});
               chk("rsp_ovf", {31'd0, rovf}, {31'd0, e.ovf});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        id;
      logic [31:0] f;
      logic [31:0] i;
      logic        ovf;
   } vec_t;
   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b0, 32'h4070_0000, 32'h0000_0003, 1'b0};
      vecs[1] = '{1'b1, 32'h4F00_0000, 32'h8000_0000, 1'b1};
      vecs[2] = '{1'b0, 32'hCF00_0000, 32'h8000_0000, 1'b0};
      vecs[3] = '{1'b1, 32'h7FC0_0000, 32'h8000_0000, 1'b1};
      vecs[4] = '{1'b0, 32'h3F00_0000, 32'h0000_0000, 1'b0};
      vecs[5] = '{1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};
      vecs[6] = '{1'b0, 32'hC2F6_E666, 32'hFFFF_FF85, 1'b0};
      vecs[7] = '{1'b1, 32'h4B00_0001, 32'h0080_0001, 1'b0};
      vecs[8] = '{1'b0, 32'h7F80_0000, 32'h8000_0000, 1'b1};
      vecs[9] = '{1'b1, 32'hCF00_0001, 32'h8000_0000, 1'b1};

      rstn = 1'b0;
      v0 = 1'b1; d0 = 32'h4070_0000;
      v1 = 1'b1; d1 = 32'h4040_0000;
      rr = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_valid", {31'd0, rv}, 32'd0);
      chk("reset_data", rdat, 32'd0);
      chk("reset_id", {31'd0, rid}, 32'd0);
      chk("reset_ovf", {31'd0, rovf}, 32'd0);
      chk("reset_ready0", {31'd0, r0}, 32'd0);
      chk("reset_ready1", {31'd0, r1}, 32'd0);
      v0 = 1'b0;
      v1 = 1'b0;
      rstn = 1'b1;

      // single operands through the converter, both requesters
      tick();
      rr = 1'b1;
      foreach (vecs[k]) send(vecs[k].id, vecs[k].f, vecs[k].i, vecs[k].ovf);

      // fresh reset, then both requesters valid every cycle
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      rr = 1'b1;
      q.push_back('{d: 32'd2, id: 1'b0, ovf: 1'b0});
      q.push_back('{d: 32'd3, id: 1'b1, ovf: 1'b0});
      q.push_back('{d: 32'd2, id: 1'b0, ovf: 1'b0});
      q.push_back('{d: 32'd3, id: 1'b1, ovf: 1'b0});
      v0 = 1'b1; d0 = 32'h4000_0000;
      v1 = 1'b1; d1 = 32'h4040_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_ready0", {31'd0, r0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_ready1", {31'd0, r1}, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("fix_ready0", {31'd0, f_r0}, 32'd1);
         chk("fix_ready1", {31'd0, f_r1}, 32'd0);
         if (i > 0) begin
            chk("fix_rsp_valid", {31'd0, f_rv}, 32'd1);
            chk("fix_rsp_id", {31'd0, f_rid}, 32'd0);
         end
      end
      tick();
      v0 = 1'b0;
      v1 = 1'b0;

      // backpressure: -2.5 from requester 1 held for three cycles
      tick();
      rr = 1'b0;
      q.push_back('{d: 32'hFFFF_FFFE, id: 1'b1, ovf: 1'b0});
      q.push_back('{d: 32'd10, id: 1'b0, ovf: 1'b0});
      v1 = 1'b1; d1 = 32'hC020_0000;
      @(negedge clk);
      chk("bp_accept1", {31'd0, r1}, 32'd1);
      tick();
      v1 = 1'b0;
      v0 = 1'b1; d0 = 32'h4120_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, rv}, 32'd1);
         chk("bp_data", rdat, 32'hFFFF_FFFE);
         chk("bp_id", {31'd0, rid}, 32'd1);
         chk("bp_ready0", {31'd0, r0}, 32'd0);
         chk("bp_ready1", {31'd0, r1}, 32'd0);
      end
      tick();
      rr = 1'b1;
      @(negedge clk);
      chk("bp_release_ready0", {31'd0, r0}, 32'd1);
      tick();
      v0 = 1'b0;
      @(negedge clk);

      // reset while FULL and backpressured; held result must vanish
      tick();
      rr = 1'b0;
      v0 = 1'b1; d0 = 32'h40A0_0000;
      @(negedge clk);
      chk("rst_pre_accept", {31'd0, r0}, 32'd1);
      tick();
      v0 = 1'b0;
      @(negedge clk);
      chk("rst_pre_full", {31'd0, rv}, 32'd1);
      #2;
      v0 = 1'b1; d0 = 32'h4100_0000;
      v1 = 1'b1; d1 = 32'h4110_0000;
      rstn = 1'b0;
      #1;
      chk("rst_async_valid", {31'd0, rv}, 32'd0);
      chk("rst_async_data", rdat, 32'd0);
      chk("rst_ready0", {31'd0, r0}, 32'd0);
      chk("rst_ready1", {31'd0, r1}, 32'd0);
      rr = 1'b1;
      q.push_back('{d: 32'd8, id: 1'b0, ovf: 1'b0});
      q.push_back('{d: 32'd9, id: 1'b1, ovf: 1'b0});
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("post_rst_tie_ready0", {31'd0, r0}, 32'd1);
      chk("post_rst_tie_ready1", {31'd0, r1}, 32'd0);
      tick();
      @(negedge clk);
      chk("post_rst_next_ready1", {31'd0, r1}, 32'd1);
      tick();
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fcvt_arb.md
FCVT_ARB -- requirements
Module: fcvt_arb

Interface
REQ-001 SHALL have parameter FAIR, default 1; 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N presents a float operand.
REQ-005 SHALL have ports req0_data / req1_data  input  32  IEEE-754 single operand.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  operand of requester N is accepted this cycle.
REQ-007 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-008 SHALL have port rsp_data  output  32  signed 32-bit integer result.
REQ-009 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-010 SHALL have port rsp_ovf  output  1  operand out of int32 range, Inf or NaN.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes the result this cycle.

Function
REQ-012 SHALL use one shared float-to-int converter: truncation toward zero; exponent below 127 gives 0; saturating encodings give 0x80000000.
REQ-013 SHALL implement states EMPTY (rsp_valid=0) and FULL (rsp_valid=1) for the single output register.
REQ-014 SHALL define accept_ok = EMPTY or (FULL and rsp_ready).
REQ-015 SHALL define a grant: if only one reqN_valid, that requester; if both, FAIR=1 selects the requester not granted last, and FAIR=0 selects requester 0.
REQ-016 SHALL drive reqN_ready = accept_ok and grant==N, combinationally; reqN_ready SHALL never be 1 while reqN_valid is 0.
REQ-017 SHALL, on acceptance, load rsp_data, rsp_id and rsp_ovf at the next edge and set rsp_valid: latency 1 cycle.
REQ-018 SHALL sustain 1 result per cycle when rsp_ready is held high (drain and load in the same cycle).
REQ-019 SHALL move from FULL to EMPTY only on rsp_ready with no acceptance; FULL with rsp_ready and an acceptance stays FULL with new contents.
REQ-020 SHALL hold rsp_data, rsp_id and rsp_ovf stable while rsp_valid=1 and rsp_ready=0 (backpressure).
REQ-021 SHALL update last_grant only on an actual acceptance; idle cycles leave it unchanged.
REQ-022 SHALL set rsp_ovf = 1 when exponent > 8'h9E, or exponent = 8'h9E except the exact value -2^31 (sign=1, mantissa=0).
REQ-023 SHALL not pass requester data through while it is not accepted; a requester SHALL keep valid and data until ready (protocol rule on the requester side).

Reset
REQ-024 SHALL, while rstn=0, force rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, and last_grant=1, so requester 0 wins the first tie.
REQ-025 SHALL discard a held result on reset asserted mid-operation; no response is replayed after reset.
REQ-026 SHALL drive reqN_ready = 0 while rstn=0.

Structure
REQ-027 SHALL take from shared package fcvt_pkg: state enum {EMPTY, FULL}, constant FCVT_EXP_OVF = 8'h9E, and the requester-ID width (1).
REQ-028 SHALL instantiate the team's existing combinational float-to-int module unchanged as its only sub-module; arbitration and the register live in fcvt_arb.

Verification
REQ-029 SHALL cover: req0 0x40700000 (3.75) with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=3, rsp_id=0, rsp_ovf=0.
REQ-030 SHALL cover: both requesters valid every cycle, FAIR=1, rsp_ready=1 -> rsp_id sequence 0,1,0,1; with FAIR=0 -> all 0 and req1_ready=0.
REQ-031 SHALL cover: req1 0xC0200000 (-2.5) then rsp_ready=0 for 3 cycles -> rsp_data=0xFFFFFFFE held stable, both readys 0, and a new request accepted on the first rsp_ready=1 cycle.
REQ-032 SHALL cover: operands 0x4F000000 (2^31) -> rsp_ovf=1, data 0x80000000; 0xCF000000 (-2^31) -> rsp_ovf=0, data 0x80000000; 0x7FC00000 (NaN) -> rsp_ovf=1.
REQ-033 SHALL cover: rstn pulled low while FULL and backpressured -> rsp_valid=0 immediately; after release, a tie grants requester 0.
